inst_mem_arbiter: RTL and testbench
===================================

INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width (2^ADDR_W words).
REQ-002 Parameter MAX_WAIT, default 4, consecutive denied fetch cycles before fetch is forced a grant.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 FetchReq in 1 / FetchAddr in 32: processor instruction-fetch request, byte address.
REQ-006 FetchGnt out 1 / FetchValid out 1 / FetchInst out 32 / FetchErr out 1: grant, response strobe, instruction, address error.
REQ-007 LdReq in 1 / LdWe in 1 / LdAddr in 32 / LdWdata in 32: loader (boot/debug) read or write request, byte address.
REQ-008 LdGnt out 1 / LdValid out 1 / LdRdata out 32 / LdErr out 1: grant, response strobe, read data, address error.
REQ-009 MemEn out 1 / MemWe out 1 / MemAddr out ADDR_W / MemWdata out 32 / MemRdata in 32: single-port synchronous instruction memory, read data one cycle after MemEn.

Function
REQ-010 Arbitration is combinational within the cycle; at most one of FetchGnt, LdGnt high per cycle.
REQ-011 Requester holds Req, Addr, We, Wdata stable until it sees Gnt high; Req may drop after the grant cycle.
REQ-012 Priority: loader wins on simultaneous requests unless the starvation counter equals MAX_WAIT, then fetch wins.
REQ-013 Starvation counter: +1 each cycle FetchReq=1 and FetchGnt=0; cleared on FetchGnt or FetchReq=0; saturates at MAX_WAIT.
REQ-014 Address legal only if Addr[1:0]=0 and Addr[31:ADDR_W+2]=0; MemAddr = Addr[ADDR_W+1:2].
REQ-015 Legal granted request: MemEn=1 in the grant cycle; MemWe=LdWe for loader, 0 for fetch; MemWdata=LdWdata.
REQ-016 Illegal granted request: granted normally, MemEn=0, response carries Err=1 and data 0.
REQ-017 Response state register: IDLE, F_RESP, L_RESP, loaded every cycle from the grant decision; no grant -> IDLE.
REQ-018 In F_RESP: FetchValid=1 for exactly one cycle, FetchInst=MemRdata (0 if error), FetchErr per REQ-016.
REQ-019 In L_RESP: LdValid=1 for one cycle; read -> LdRdata=MemRdata; write ack -> LdRdata=0; LdErr per REQ-016.
REQ-020 Latency: request granted in cycle N responds in cycle N+1; back-to-back grants every cycle sustained, full throughput.
REQ-021 FetchInst and LdRdata hold their last delivered value while the respective Valid is 0.
REQ-022 Outside grant cycles MemEn=0, MemWe=0, MemAddr=0, MemWdata=0.
REQ-023 Write then read of same word in consecutive cycles returns new data (memory write-first ordering, no bypass in this block).

Reset
REQ-024 While Rst=1: no grants, MemEn=0, MemWe=0, state=IDLE, counter=0, all Valid/Err=0, FetchInst=0, LdRdata=0.
REQ-025 Rst asserted in cycle N cancels any response due in N+1; no Valid pulse follows reset.
REQ-026 First grant possible in the first cycle with Rst=0.

Configuration
REQ-027 Macro ARB_STARVE_GUARD_EN defined: starvation counter and REQ-012 forced fetch grant active.
REQ-028 Macro undefined: no counter logic; strict loader priority, fetch granted only when LdReq=0; MAX_WAIT ignored.

Verification
REQ-029 Fetch only, FetchAddr=0x8, MemRdata word2=0x00500093 -> FetchGnt cycle N, FetchValid N+1, FetchInst=0x00500093.
REQ-030 Loader write 0x0C<-0xDEADBEEF then fetch 0x0C -> LdValid ack with LdRdata=0, then FetchInst=0xDEADBEEF.
REQ-031 FetchReq and LdReq held high continuously, MAX_WAIT=4, guard on -> 4 loader grants, 1 fetch grant, repeating; guard off -> fetch never granted.
REQ-032 FetchAddr=0x6 and FetchAddr=0x1000 (ADDR_W=10) -> MemEn=0, FetchValid=1, FetchErr=1, FetchInst=0.
REQ-033 Fetch granted cycle N, Rst=1 in cycle N -> no FetchValid at N+1, all outputs at reset values.

Source files
------------

// File: rtl/inst_mem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch port, loader port and single-port memory port.
interface inst_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic              fetch_err;

  logic              ld_req;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_valid;
  logic [31:0]       ld_rdata;
  logic              ld_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_inst, fetch_err,
    output ld_gnt, ld_valid, ld_rdata, ld_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_inst, fetch_err,
    input  ld_gnt, ld_valid, ld_rdata, ld_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Fetch/loader arbiter for a single-port synchronous instruction memory, one-cycle response.
// Define ARB_STARVE_GUARD_EN to enable the fetch starvation counter and forced fetch grant.
module inst_mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  inst_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_RESP = 2'd1,
    L_RESP = 2'd2
  } resp_state_e;

  // Elaboration-time parameter sanity check
  if (ADDR_W < 1 || ADDR_W > 30 || MAX_WAIT > 65535) begin : g_bad_cfg
    $error("inst_mem_arbiter: unsupported ADDR_W/MAX_WAIT");
  end

  resp_state_e       state_q, state_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [31:0]       fetch_inst_q;
  logic [31:0]       ld_rdata_q;
  logic              fetch_legal;
  logic              ld_legal;
  logic              starved;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
  endfunction

  assign fetch_legal = addr_legal(bus.fetch_addr);
  assign ld_legal    = addr_legal(bus.ld_addr);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_q;

  assign starved = (wait_q == CNT_W'(MAX_WAIT));

  // Consecutive denied fetch cycles, saturating at MAX_WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (!bus.fetch_req || bus.fetch_gnt) begin
      wait_q <= '0;
    end else if (!starved) begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Response state, error/write flags and delivered-data hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      fetch_inst_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      fetch_inst_q <= bus.fetch_inst;
      ld_rdata_q   <= bus.ld_rdata;
    end
  end

  // Grant decision, memory command, next response state and response outputs
  always_comb begin
    bus.fetch_gnt   = 1'b0;
    bus.ld_gnt      = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_err   = 1'b0;
    bus.fetch_inst  = fetch_inst_q;
    bus.ld_valid    = 1'b0;
    bus.ld_err      = 1'b0;
    bus.ld_rdata    = ld_rdata_q;
    state_d         = IDLE;
    err_d           = 1'b0;
    wr_d            = 1'b0;

    if (rst) begin
      bus.fetch_inst = '0;
      bus.ld_rdata   = '0;
    end else begin
      if (bus.fetch_req && (!bus.ld_req || starved)) begin
        bus.fetch_gnt = 1'b1;
        state_d       = F_RESP;
        err_d         = !fetch_legal;
        if (fetch_legal) begin
          bus.mem_en    = 1'b1;
          bus.mem_addr  = bus.fetch_addr[ADDR_W+1:2];
          bus.mem_wdata = bus.ld_wdata;
        end
      end else if (bus.ld_req) begin
        bus.ld_gnt = 1'b1;
        state_d    = L_RESP;
        err_d      = !ld_legal;
        wr_d       = bus.ld_we;
        if (ld_legal) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.ld_we;
          bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
          bus.mem_wdata = bus.ld_wdata;
        end
      end

      // A reset cycle suppresses any response that was due
      case (state_q)
        F_RESP: begin
          bus.fetch_valid = 1'b1;
          bus.fetch_err   = err_q;
          bus.fetch_inst  = err_q ? 32'd0 : bus.mem_rdata;
        end
        L_RESP: begin
          bus.ld_valid = 1'b1;
          bus.ld_err   = err_q;
          bus.ld_rdata = (err_q || wr_q) ? 32'd0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_inst_mem_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst;

  inst_mem_arbiter_if #(.ADDR_W(ADDR_W)) mif ();

  inst_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          streak;
  bit          pend_f, pend_f_err, pend_l, pend_l_err;
  logic [31:0] pend_f_data, pend_l_data;
  logic [31:0] fi_hold, lr_hold;
  bit          last_xf, last_xl;
  int          n_fgnt, n_lgnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(DEPTH * 4));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0) return $urandom();
    if (r == 1) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    if (r == 2) return 32'((DEPTH - 1) * 4);
    if (r == 3) return 32'(DEPTH * 4);
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // One clock cycle: check responses and grant/memory outputs, advance the model, play memory
  task automatic step();
    bit          xf, xl, lg, xen, xwe;
    bit          cen, cwe;
    logic [ADDR_W-1:0] caddr;
    logic [31:0] a, cwd;
    int unsigned idx;
    @(negedge clk);
    if (rst) begin
      pend_f = 0; pend_l = 0; fi_hold = '0; lr_hold = '0;
    end else begin
      if (pend_f) fi_hold = pend_f_data;
      if (pend_l) lr_hold = pend_l_data;
    end
    chk("fetch_valid", 32'(mif.fetch_valid), 32'(pend_f));
    chk("fetch_err",   32'(mif.fetch_err),   32'(pend_f && pend_f_err));
    chk("fetch_inst",  mif.fetch_inst,       fi_hold);
    chk("ld_valid",    32'(mif.ld_valid),    32'(pend_l));
    chk("ld_err",      32'(mif.ld_err),      32'(pend_l && pend_l_err));
    chk("ld_rdata",    mif.ld_rdata,         lr_hold);

    xf = 0; xl = 0; xen = 0; xwe = 0; idx = 0; pend_f = 0; pend_l = 0;
    if (rst) begin
      streak = 0;
    end else begin
      xf = mif.fetch_req && (!mif.ld_req || (GUARD && streak == int'(MAX_WAIT)));
      xl = mif.ld_req && !xf;
      if (mif.fetch_req && !xf) streak = (streak < int'(MAX_WAIT)) ? streak + 1 : streak;
      else streak = 0;
    end
    if (xf) begin
      a = mif.fetch_addr; lg = legal(a); idx = widx(a);
      xen = lg; pend_f = 1; pend_f_err = !lg;
      pend_f_data = lg ? ref_mem[idx] : 32'd0;
    end
    if (xl) begin
      a = mif.ld_addr; lg = legal(a); idx = widx(a);
      xen = lg; xwe = lg && mif.ld_we; pend_l = 1; pend_l_err = !lg;
      pend_l_data = (lg && !mif.ld_we) ? ref_mem[idx] : 32'd0;
      if (xwe) ref_mem[idx] = mif.ld_wdata;
    end
    chk("fetch_gnt", 32'(mif.fetch_gnt), 32'(xf));
    chk("ld_gnt",    32'(mif.ld_gnt),    32'(xl));
    chk("mem_en",    32'(mif.mem_en),    32'(xen));
    chk("mem_we",    32'(mif.mem_we),    32'(xwe));
    if (xen) chk("mem_addr", 32'(mif.mem_addr), 32'(idx));
    if (xen && xl) chk("mem_wdata", mif.mem_wdata, mif.ld_wdata);
    if (!xf && !xl) begin
      chk("mem_addr_idle",  32'(mif.mem_addr), 32'd0);
      chk("mem_wdata_idle", mif.mem_wdata,     32'd0);
    end
    if (mif.fetch_gnt) n_fgnt++;
    if (mif.ld_gnt)    n_lgnt++;
    last_xf = xf; last_xl = xl;
    cen = mif.mem_en; cwe = mif.mem_we; caddr = mif.mem_addr; cwd = mif.mem_wdata;
    @(posedge clk);
    #1;
    if (cen && cwe) env_mem[caddr] = cwd;
    mif.mem_rdata = (cen && !cwe) ? env_mem[caddr] : $urandom();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; streak = 0;
    pend_f = 0; pend_l = 0; pend_f_err = 0; pend_l_err = 0;
    pend_f_data = '0; pend_l_data = '0; fi_hold = '0; lr_hold = '0;
    last_xf = 0; last_xl = 0; n_fgnt = 0; n_lgnt = 0;
    rst = 1'b1;
    mif.fetch_req = 1'b0; mif.fetch_addr = '0;
    mif.ld_req = 1'b0; mif.ld_we = 1'b0; mif.ld_addr = '0; mif.ld_wdata = '0;
    mif.mem_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    env_mem[2] = 32'h0050_0093;
    ref_mem[2] = 32'h0050_0093;

    // Reset with both requests pending: nothing granted
    mif.fetch_req = 1'b1; mif.fetch_addr = 32'h8;
    mif.ld_req = 1'b1; mif.ld_addr = 32'h10;
    step();
    step();

    // First cycle out of reset: fetch of word 2 granted, instruction next cycle
    rst = 1'b0; mif.ld_req = 1'b0;
    step();
    #1;
    chk("req029_valid", 32'(mif.fetch_valid), 32'd1);
    chk("req029_inst",  mif.fetch_inst, 32'h0050_0093);
    mif.fetch_req = 1'b0;
    step();

    // Loader write then fetch of the same word
    mif.ld_req = 1'b1; mif.ld_we = 1'b1; mif.ld_addr = 32'h0C; mif.ld_wdata = 32'hDEAD_BEEF;
    step();
    mif.ld_req = 1'b0; mif.ld_we = 1'b0;
    mif.fetch_req = 1'b1; mif.fetch_addr = 32'h0C;
    #1;
    chk("req030_ack_valid", 32'(mif.ld_valid), 32'd1);
    chk("req030_ack_rdata", mif.ld_rdata, 32'd0);
    step();
    mif.fetch_req = 1'b0;
    #1;
    chk("req030_inst", mif.fetch_inst, 32'hDEAD_BEEF);
    step();

    // Misaligned and out-of-range fetch addresses
    mif.fetch_req = 1'b1; mif.fetch_addr = 32'h6;
    step();
    mif.fetch_addr = 32'h1000;
    #1;
    chk("req032a_err",  32'(mif.fetch_err), 32'd1);
    chk("req032a_inst", mif.fetch_inst, 32'd0);
    step();
    mif.fetch_req = 1'b0;
    #1;
    chk("req032b_err",  32'(mif.fetch_err), 32'd1);
    chk("req032b_inst", mif.fetch_inst, 32'd0);
    step();

    // Both requesters held high: starvation pattern
    mif.fetch_req = 1'b1; mif.fetch_addr = 32'h8;
    mif.ld_req = 1'b1; mif.ld_we = 1'b0; mif.ld_addr = 32'h0C;
    n_fgnt = 0; n_lgnt = 0;
    for (int c = 0; c < 20; c++) step();
    chk("req031_fetch_grants", 32'(n_fgnt), GUARD ? 32'd4 : 32'd0);
    chk("req031_ld_grants",    32'(n_lgnt), GUARD ? 32'd16 : 32'd20);
    mif.fetch_req = 1'b0; mif.ld_req = 1'b0;
    step();

    // Reset in the would-be grant cycle, then reset right after a grant
    rst = 1'b1; mif.fetch_req = 1'b1; mif.fetch_addr = 32'h8;
    step();
    rst = 1'b0; mif.fetch_req = 1'b0;
    #1;
    chk("req033_no_valid", 32'(mif.fetch_valid), 32'd0);
    step();
    mif.fetch_req = 1'b1;
    step();
    rst = 1'b1; mif.fetch_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Randomized traffic honouring hold-until-grant
    for (int c = 0; c < 400; c++) begin
      if (!(mif.fetch_req && !last_xf)) begin
        mif.fetch_req  = ($urandom_range(0, 99) < 60);
        mif.fetch_addr = rand_addr();
      end
      if (!(mif.ld_req && !last_xl)) begin
        mif.ld_req   = ($urandom_range(0, 99) < 50);
        mif.ld_we    = 1'($urandom_range(0, 1));
        mif.ld_addr  = rand_addr();
        mif.ld_wdata = $urandom();
      end
      rst = (c % 97 == 50);
      step();
    end
    rst = 1'b0; mif.fetch_req = 1'b0; mif.ld_req = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
